// File: rtl/full_adder_pkg.sv
// Shared definitions for the ripple-carry adder: legal width range and the
// per-bit sum/carry equations used by the leaf cell.
package full_adder_pkg;

    localparam int MIN_WIDTH = 1;
    localparam int MAX_WIDTH = 64;

    function automatic logic sum_bit(input logic a, input logic b, input logic ci);
        return a ^ b ^ ci;
    endfunction

    // Generate when both operands are set, propagate an incoming carry otherwise.
    function automatic logic carry_bit(input logic a, input logic b, input logic ci);
        return (a & b) | (ci & (a ^ b));
    endfunction

endpackage

// File: rtl/full_adder_if.sv
// Operand/result bundle for full_adder; clk and rst_n stay outside the bundle.
// There is no handshake: operands are consumed every cycle.
interface full_adder_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;
    logic [WIDTH-1:0] s;
    logic             c_out;
    logic [WIDTH-1:0] s_q;
    logic             c_out_q;

    modport master (
        output a, b, c,
        input  s, c_out, s_q, c_out_q
    );

    modport slave (
        input  a, b, c,
        output s, c_out, s_q, c_out_q
    );
endinterface

// File: rtl/full_adder_bit.sv
// One-bit full adder cell; chained through its carry to build wider adders.
module full_adder_bit
    import full_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = sum_bit(a, b, ci);
    assign co = carry_bit(a, b, ci);

endmodule

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder: combinational {c_out, s} = a + b + c plus a
// one-cycle registered copy that is cleared by a synchronous active-low reset.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic [WIDTH-1:0] s_q,
    output logic             c_out_q
);

    // cy[i] is the carry into bit i; cy[WIDTH] leaves the top bit.
    logic [WIDTH:0] cy;

    assign cy[0] = c;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            full_adder_bit u_bit (
                .a  (a[gi]),
                .b  (b[gi]),
                .ci (cy[gi]),
                .s  (s[gi]),
                .co (cy[gi+1])
            );
        end
    endgenerate

    assign c_out = cy[WIDTH];

    // Reset only clears the registered copy; the combinational path keeps tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q     <= '0;
            c_out_q <= 1'b0;
        end else begin
            s_q     <= s;
            c_out_q <= c_out;
        end
    end

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench: WIDTH=1 and WIDTH=8 adders checked against integer
// arithmetic, directed corner cases, and 1000 random vectors.
`timescale 1ns/1ps
module tb_full_adder;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    full_adder_if #(.WIDTH(1)) if1 ();
    full_adder_if #(.WIDTH(8)) if8 ();

    full_adder #(.WIDTH(1)) u_dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (if1.a),
        .b       (if1.b),
        .c       (if1.c),
        .s       (if1.s),
        .c_out   (if1.c_out),
        .s_q     (if1.s_q),
        .c_out_q (if1.c_out_q)
    );

    full_adder #(.WIDTH(8)) u_dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (if8.a),
        .b       (if8.b),
        .c       (if8.c),
        .s       (if8.s),
        .c_out   (if8.c_out),
        .s_q     (if8.s_q),
        .c_out_q (if8.c_out_q)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer sum at one extra bit.
    function automatic logic [8:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic c);
        int unsigned t;
        t = int'(a) + int'(b) + int'(c);
        return t[8:0];
    endfunction

    function automatic logic [1:0] ref1(input logic a, input logic b, input logic c);
        int unsigned t;
        t = int'(a) + int'(b) + int'(c);
        return t[1:0];
    endfunction

    task automatic drive_random();
        if8.a = 8'($urandom_range(0, 255));
        if8.b = 8'($urandom_range(0, 255));
        if8.c = 1'($urandom_range(0, 1));
        if1.a = 1'($urandom_range(0, 1));
        if1.b = 1'($urandom_range(0, 1));
        if1.c = 1'($urandom_range(0, 1));
    endtask

    logic [8:0] exp_q[$];
    logic [1:0] exp1_q[$];
    logic [8:0] e8;
    logic [1:0] e1;
    logic [1:0] tbl [8];
    logic [2:0] v;

    initial begin
        total = 0;
        bad   = 0;
        tbl   = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        rst_n = 1'b0;
        if1.a = 1'b0; if1.b = 1'b0; if1.c = 1'b0;
        if8.a = 8'h00; if8.b = 8'h00; if8.c = 1'b0;

        // Reset state of the registered outputs.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_q_w1", 64'(if1.s_q), 64'd0);
        check("rst_cq_w1", 64'(if1.c_out_q), 64'd0);
        check("rst_s_q_w8", 64'(if8.s_q), 64'd0);
        check("rst_cq_w8", 64'(if8.c_out_q), 64'd0);

        // Exhaustive 1-bit truth table, 1 time unit apart, away from edges.
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            if1.a = v[2]; if1.b = v[1]; if1.c = v[0];
            #1;
            check($sformatf("tt_w1_%0d", i), 64'({if1.c_out, if1.s}), 64'(tbl[i]));
        end

        // Registered capture out of reset.
        @(negedge clk);
        rst_n = 1'b1;
        if1.a = 1'b1; if1.b = 1'b1; if1.c = 1'b1;
        @(posedge clk); #1;
        check("reg_s_q_111", 64'(if1.s_q), 64'd1);
        check("reg_cq_111", 64'(if1.c_out_q), 64'd1);

        // Reset dominates an input change; combinational path keeps tracking.
        @(negedge clk);
        rst_n = 1'b0;
        if1.a = 1'b1; if1.b = 1'b1; if1.c = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_s_q", 64'(if1.s_q), 64'd0);
        check("rst_mid_cq", 64'(if1.c_out_q), 64'd0);
        check("rst_mid_s", 64'(if1.s), 64'd0);
        check("rst_mid_c_out", 64'(if1.c_out), 64'd1);

        // 8-bit wrap-around corners.
        if8.a = 8'hFF; if8.b = 8'h01; if8.c = 1'b0;
        #1;
        check("wrap_ff_01_s", 64'(if8.s), 64'h00);
        check("wrap_ff_01_c", 64'(if8.c_out), 64'd1);
        if8.a = 8'hFF; if8.b = 8'hFF; if8.c = 1'b1;
        #1;
        check("wrap_ff_ff_1_s", 64'(if8.s), 64'hFF);
        check("wrap_ff_ff_1_c", 64'(if8.c_out), 64'd1);

        // Random inputs held in reset: registers stay clear.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_random();
            @(posedge clk); #1;
            check("hold_rst_s_q", 64'(if8.s_q), 64'd0);
            check("hold_rst_cq", 64'(if8.c_out_q), 64'd0);
        end

        // Release reset mid-stream, then 1000 random vectors.
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            drive_random();
            #1;
            e8 = ref8(if8.a, if8.b, if8.c);
            e1 = ref1(if1.a, if1.b, if1.c);
            check("rand_comb_w8", 64'({if8.c_out, if8.s}), 64'(e8));
            check("rand_comb_w1", 64'({if1.c_out, if1.s}), 64'(e1));
            exp_q.push_back(e8);
            exp1_q.push_back(e1);
            @(posedge clk); #1;
            e8 = exp_q.pop_front();
            e1 = exp1_q.pop_front();
            check("rand_reg_w8", 64'({if8.c_out_q, if8.s_q}), 64'(e8));
            check("rand_reg_w1", 64'({if1.c_out_q, if1.s_q}), 64'(e1));
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
